fmul_res_checker: RTL
=====================

# fmul_res_checker

Synthesizable result-side checker for the FMUL32 datapath: consumes the `result`/`val` stream leaving the multiplier and compares each result, in order, against an expected value pushed earlier by the stimulus side. Holds expected values in a small in-order FIFO, counts passes and failures, and captures the first mismatch. Sits at the output end of the on-chip FMUL32 self-test harness, opposite the vector player that drives `op1`/`op2`.

## Interface
- `DATA_W`, 32, operand/result width
- `DEPTH`, 8, expected-value FIFO depth (power of two, ≥2)
- `CNT_W`, 16, width of vector counters and indices
- `STOP_ON_ERR`, 0, 1 = finish on first mismatch
- `NAN_EQ`, 1, 1 = any NaN equals any NaN (exp field all ones, mantissa ≠0)

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `start` in 1 — arm a run (accepted only in IDLE or DONE)
- `n_vec` in CNT_W — number of results to check, sampled with `start`
- `exp_data` in DATA_W — expected result
- `exp_push` in 1 — push `exp_data` into FIFO
- `exp_full` out 1 — FIFO full
- `res_data` in DATA_W — FMUL32 `result`
- `res_val` in 1 — FMUL32 `val`
- `busy` out 1 — state RUN
- `done` out 1 — state DONE
- `pass` out 1 — done, zero errors, no overflow/underflow
- `ok_cnt`, `err_cnt` out CNT_W — compare counters
- `err_idx` out CNT_W — index of first mismatch
- `err_got`, `err_exp` out DATA_W — values at first mismatch
- `overflow`, `underflow` out 1 — sticky FIFO misuse flags

## Operation
- States: IDLE → RUN → DONE; DONE → RUN on `start`; `start` in RUN ignored.
- `start` (IDLE/DONE): clear FIFO, counters, capture regs, sticky flags; load `n_vec`; go RUN. With `n_vec`=0 go DONE instead, `pass`=1.
- Pushes accepted only in RUN; a push in the `start` cycle is dropped.
- Push while full with no pop that cycle: value dropped, `overflow` set. Push and pop in the same cycle while full: both succeed.
- In RUN, `res_val`=1: pop head, compare. Equal → `ok_cnt`+1; else `err_cnt`+1 and, if first error, capture `err_idx`=checked count (0-based), `err_got`, `err_exp`.
- `res_val` with empty FIFO: counts as an error, sets `underflow`, captures `err_exp`=0. No bypass from a same-cycle push.
- Equality: bitwise; with `NAN_EQ`=1, two NaNs compare equal regardless of sign/payload. +0 and −0 differ.
- After `ok_cnt+err_cnt` reaches `n_vec` → DONE. `STOP_ON_ERR`=1: first error → DONE.
- DONE: `res_val`, `exp_push` ignored; outputs hold until `start`/`reset`.
- Counters saturate at all-ones.

## Timing
- Reset: state IDLE; all outputs 0 (`busy`, `done`, `pass`, counters, capture regs, flags, `exp_full`).
- Compare is registered: `res_val` at edge t → counters/capture visible after edge t+1.
- `done` asserts the cycle after the final compare's update edge (same edge as counter update); `busy` deasserts the same cycle.
- `exp_full` is registered FIFO state, no combinational path from `exp_push`.
- `reset` mid-run aborts immediately to reset values; no partial results retained.

## Structure
- Shared package `fmul_pkg`: state encoding (IDLE/RUN/DONE), FP32 field constants (exp position/width, mantissa width), `is_nan` function.
- Sub-module `chk_fifo` (sync FIFO, DATA_W × DEPTH, count-based full/empty, simultaneous push/pop). Top holds FSM, comparator, counters, capture.

## Test plan
- n_vec=3; push 0x3F800000, 0x40000000, 0xC0400000; results identical → done, pass=1, ok_cnt=3, err_cnt=0.
- n_vec=4; result #2 = 0x40000001 vs exp 0x40000000 → err_cnt=1, err_idx=2, err_got=0x40000001, err_exp=0x40000000, pass=0.
- NAN_EQ=1: exp 0x7FC00000, got 0xFFC00001 → ok; exp 0x00000000, got 0x80000000 → error.
- DEPTH=8: 9 pushes with no results → exp_full after 8th, overflow=1; result with empty FIFO → underflow=1, err_cnt+1.
- STOP_ON_ERR=1, n_vec=10, mismatch at index 1 → done after 2 compares, ok_cnt=1, later res_val ignored.
- reset asserted mid-run after 5 compares → all outputs 0 immediately; new start with n_vec=0 → done, pass=1 next cycle.

Source files
------------

// File: rtl/fmul_pkg.sv
// Shared FMUL32 self-test definitions: checker state encoding, FP32 field layout, NaN test.
// Combinational helpers only; no timing or flow-control behaviour.
package fmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    localparam int FP_EXP_LSB = 23;
    localparam int FP_EXP_W   = 8;
    localparam int FP_MAN_W   = 23;

    function automatic logic is_nan(input logic [31:0] v);
        return (&v[FP_EXP_LSB +: FP_EXP_W]) && (|v[FP_MAN_W-1:0]);
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// In-order expected-value FIFO, count-based full/empty, same-cycle push+pop; head visible with 0 latency.
// No internal protection: the caller must not push when full (unless popping) nor pop when empty.
module chk_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; only entries covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/fmul_res_checker.sv
// FMUL32 result checker: in-order compare of res_data against queued expectations; counters/capture update 1 cycle after res_val.
// No backpressure: results are always consumed, pushes on a full FIFO are dropped and flagged as overflow.
module fmul_res_checker
    import fmul_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0,
    parameter bit NAN_EQ      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_vec,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_push,
    output logic              exp_full,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_val,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  ok_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  err_idx,
    output logic [DATA_W-1:0] err_got,
    output logic [DATA_W-1:0] err_exp,
    output logic              overflow,
    output logic              underflow
);
    chk_state_t        st;
    chk_state_t        st_nxt;
    logic [CNT_W-1:0]  n_reg;
    logic [DATA_W-1:0] head_dat;
    logic              fifo_full;
    logic              fifo_empty;

    logic              run;
    logic              arm;
    logic              cmp_vld;
    logic              pop_vld;
    logic              push_vld;
    logic              push_drop;
    logic [DATA_W-1:0] cmp_exp;
    logic              cmp_ok;
    logic [CNT_W:0]    checked;
    logic [CNT_W:0]    checked_nxt;
    logic              last_cmp;

    assign run       = (st == ST_RUN);
    assign arm       = start && (st != ST_RUN);
    assign cmp_vld   = run && res_val;
    assign pop_vld   = cmp_vld && !fifo_empty;
    assign push_vld  = run && exp_push && (!fifo_full || pop_vld);
    assign push_drop = run && exp_push && fifo_full && !pop_vld;

    // An empty FIFO always scores a mismatch; the phantom expectation is zero.
    assign cmp_exp = fifo_empty ? '0 : head_dat;
    assign cmp_ok  = !fifo_empty &&
                     ((res_data == cmp_exp) ||
                      (NAN_EQ && is_nan(32'(res_data)) && is_nan(32'(cmp_exp))));

    assign checked     = {1'b0, ok_cnt} + {1'b0, err_cnt};
    assign checked_nxt = checked + (CNT_W+1)'(1);
    assign last_cmp    = cmp_vld && ((checked_nxt >= {1'b0, n_reg}) || (STOP_ON_ERR && !cmp_ok));

    chk_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (arm),
        .push  (push_vld),
        .din   (exp_data),
        .pop   (pop_vld),
        .dout  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= ST_IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            ST_IDLE, ST_DONE: if (start) st_nxt = (n_vec == '0) ? ST_DONE : ST_RUN;
            ST_RUN:           if (last_cmp) st_nxt = ST_DONE;
            default:          st_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        if (st == ST_RUN)  busy = 1'b1;
        if (st == ST_DONE) begin
            done = 1'b1;
            pass = (err_cnt == '0) && !overflow && !underflow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reg     <= '0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
            err_idx   <= '0;
            err_got   <= '0;
            err_exp   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (arm) begin
            n_reg     <= n_vec;
            ok_cnt    <= '0;
            err_cnt   <= '0;
            err_idx   <= '0;
            err_got   <= '0;
            err_exp   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (run) begin
            if (cmp_vld) begin
                if (cmp_ok) begin
                    if (ok_cnt != '1) ok_cnt <= ok_cnt + CNT_W'(1);
                end else begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    if (err_cnt == '0) begin
                        err_idx <= checked[CNT_W] ? '1 : checked[CNT_W-1:0];
                        err_got <= res_data;
                        err_exp <= cmp_exp;
                    end
                    if (fifo_empty) underflow <= 1'b1;
                end
            end
            if (push_drop) overflow <= 1'b1;
        end
    end

    assign exp_full = fifo_full;

endmodule
